aes_mix_columns_engine: RTL and testbench

//  Forward AES MixColumns for the encryption datapath; the counterpart of the decryption-side

---
 rtl/aes_mix_columns_engine.sv | 156 +++++++++++++++
 tb/tb_aes_mix_columns_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mix_columns_engine.sv
`default_nettype none
// ============================================================================
// aes_mix_columns_engine : AES MixColumns over valid/ready, COLS_PER_CYCLE cols/clk
// Optional inverse via MIXCOL_INV_EN.            Revision: 1.0
// ============================================================================
module aes_mix_columns_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
`ifdef MIXCOL_INV_EN
    ,
    input  logic         inv
`endif
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $fatal(1, "aes_mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] c_cnt_step = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] c_cnt_last = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q;
    logic [1:0]     cnt_q;
    logic [127:0]   data_q;
    logic [127:0]   data_d;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [1:0]     col_idx;
    logic           w_inv;

`ifdef MIXCOL_INV_EN
    logic           inv_q;
    assign w_inv = inv_q;
`else
    assign w_inv = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiples are built from a shared xtime chain; the inverse coefficients
    // 9/B/D/E are XOR combinations of x, 2x, 4x and 8x.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv_sel);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x3 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] x9 [4];
        logic [7:0] xb [4];
        logic [7:0] xd [4];
        logic [7:0] xe [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8 * i -: 8];
            x2[i] = xtime(a[i]);
            x3[i] = x2[i] ^ a[i];
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            x9[i] = x8[i] ^ a[i];
            xb[i] = x8[i] ^ x2[i] ^ a[i];
            xd[i] = x8[i] ^ x4[i] ^ a[i];
            xe[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (inv_sel) begin
            return {xe[0] ^ xb[1] ^ xd[2] ^ x9[3],
                    x9[0] ^ xe[1] ^ xb[2] ^ xd[3],
                    xd[0] ^ x9[1] ^ xe[2] ^ xb[3],
                    xb[0] ^ xd[1] ^ x9[2] ^ xe[3]};
        end
        return {x2[0] ^ x3[1] ^ a[2]  ^ a[3],
                a[0]  ^ x2[1] ^ x3[2] ^ a[3],
                a[0]  ^ a[1]  ^ x2[2] ^ x3[3],
                x3[0] ^ a[1]  ^ a[2]  ^ x2[3]};
    endfunction

    // Lanes touch disjoint columns, so each can read the unmodified register.
    always_comb begin
        data_d  = data_q;
        col_idx = '0;
        for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
            col_idx = cnt_q + 2'(k);
            data_d[(3 - int'(col_idx)) * 32 +: 32] =
                mix_column(data_q[(3 - int'(col_idx)) * 32 +: 32], w_inv);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef MIXCOL_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        cnt_q      <= 2'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_BUSY;
`ifdef MIXCOL_INV_EN
                        inv_q      <= inv;
`endif
                    end
                end
                S_BUSY: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q + c_cnt_step;
                    if (cnt_q == c_cnt_last) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_mix_columns_engine.sv
`default_nettype none
// ============================================================================
// tb_aes_mix_columns_engine : three engines (1, 2, 4 columns/clk) against a GF(2^8) matrix model
// Revision: 1.0
// ============================================================================
module tb_aes_mix_columns_engine;

    localparam int N = 3;

    localparam logic [127:0] T1_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] T1_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] T2_IN  = 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff;
    localparam logic [127:0] T2_OUT = 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff;

    logic         clk;
    logic         rst_n     [N];
    logic         in_valid  [N];
    logic         in_ready  [N];
    logic [127:0] in_data   [N];
    logic         out_valid [N];
    logic         out_ready [N];
    logic [127:0] out_data  [N];
`ifdef MIXCOL_INV_EN
    logic         inv       [N];
`endif

    int errs;
    int checks;

    // model state: 0 idle, 1 busy, 2 result waiting
    int           m_st   [N];
    int           m_left [N];
    logic [127:0] m_res  [N];
    bit           m_zero [N];
    int           m_acc  [N];
    int           dut_done [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            aes_mix_columns_engine #(.COLS_PER_CYCLE(1 << gi)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n[gi]),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .in_data   (in_data[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .out_data  (out_data[gi])
`ifdef MIXCOL_INV_EN
                ,
                .inv       (inv[gi])
`endif
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Generic shift-and-add GF(2^8) multiply, reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = int'(a);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11B;
        end
        return p[7:0];
    endfunction

    // Circulant matrix product on each column.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv_m);
        logic [7:0]   row0 [4];
        logic [127:0] r;
        logic [7:0]   acc;
        r = '0;
        if (inv_m) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else       row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(row0[(j - rr + 4) % 4], s[127 - 32 * c - 8 * j -: 8]);
                r[127 - 32 * c - 8 * rr -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic bit inv_of(input int d);
`ifdef MIXCOL_INV_EN
        return inv[d];
`else
        return (d < 0);
`endif
    endfunction

    task automatic check(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s [engine %0d]: got %h, expected %h", name, d, act, exp);
        end
    endtask

    // One clock: compare every engine with the model at negedge, advance the
    // model for the coming edge, then return just after that edge.
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            if (!rst_n[d]) begin
                if (m_st[d] != 0) m_acc[d]--;
                m_st[d]   = 0;
                m_zero[d] = 1'b1;
            end
            check("in_ready", d, in_ready[d], m_st[d] == 0);
            check("out_valid", d, out_valid[d], m_st[d] == 2);
            if (m_st[d] == 2)  check("out_data", d, out_data[d], m_res[d]);
            else if (m_zero[d]) check("out_data_reset", d, out_data[d], '0);
            if (rst_n[d] && out_valid[d] && out_ready[d]) dut_done[d]++;
            if (rst_n[d]) begin
                case (m_st[d])
                    0: if (in_valid[d]) begin
                        m_st[d]   = 1;
                        m_left[d] = 4 / (1 << d);
                        m_res[d]  = ref_mix(in_data[d], inv_of(d));
                        m_zero[d] = 1'b0;
                        m_acc[d]++;
                    end
                    1: begin
                        m_left[d]--;
                        if (m_left[d] == 0) m_st[d] = 2;
                    end
                    default: if (out_ready[d]) m_st[d] = 0;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [127:0] din, input logic [127:0] dexp, input bit inv_v);
        int lat_exp [3] = '{4, 2, 1};
        int first   [N];
        for (int d = 0; d < N; d++) begin
            in_data[d]   = din;
            in_valid[d]  = 1'b1;
            out_ready[d] = 1'b1;
            first[d]     = 0;
`ifdef MIXCOL_INV_EN
            inv[d]       = inv_v;
`endif
        end
        cycle();
        for (int d = 0; d < N; d++) in_valid[d] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            for (int d = 0; d < N; d++) begin
                if (out_valid[d] && first[d] == 0) begin
                    first[d] = k;
                    check({name, "_data"}, d, out_data[d], dexp);
                end
            end
        end
        for (int d = 0; d < N; d++) check({name, "_latency"}, d, first[d], lat_exp[d]);
        if (inv_v && din == '0) $display("unreachable");
    endtask

    int  base [N];
    bit  all_done;

    initial begin
        errs   = 0;
        checks = 0;
        for (int d = 0; d < N; d++) begin
            rst_n[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_data[d] = '0;
`ifdef MIXCOL_INV_EN
            inv[d] = 1'b0;
`endif
            m_st[d] = 0; m_left[d] = 0; m_res[d] = '0; m_zero[d] = 1'b1;
            m_acc[d] = 0; dut_done[d] = 0;
        end

        // hand-computed vectors pin the model itself
        check("model_fwd_T1", 0, ref_mix(T1_IN, 1'b0), T1_OUT);
        check("model_fwd_T2", 0, ref_mix(T2_IN, 1'b0), T2_OUT);
        check("model_inv_T5", 0, ref_mix(T1_OUT, 1'b1), T1_IN);

        repeat (2) cycle();
        for (int d = 0; d < N; d++) rst_n[d] = 1'b1;
        cycle();

        directed("T1", T1_IN, T1_OUT, 1'b0);
        directed("T2", T2_IN, T2_OUT, 1'b0);

        // T3: long output stall with ignored input traffic
        for (int d = 0; d < N; d++) begin
            in_data[d] = T1_IN; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
        end
        cycle();
        for (int d = 0; d < N; d++) in_data[d] = T2_IN;
        repeat (4) cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            for (int d = 0; d < N; d++) begin
                check("T3_hold_valid", d, out_valid[d], 1'b1);
                check("T3_hold_ready", d, in_ready[d], 1'b0);
                check("T3_hold_data", d, out_data[d], T1_OUT);
            end
        end
        for (int d = 0; d < N; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b1;
        end
        cycle();
        for (int d = 0; d < N; d++) check("T3_release_ready", d, in_ready[d], 1'b1);

        // T4: asynchronous reset in the middle of a computation
        for (int d = 0; d < N; d++) begin
            in_data[d] = T1_IN; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
        end
        cycle();
        for (int d = 0; d < N; d++) in_valid[d] = 1'b0;
        repeat (2) cycle();
        for (int d = 0; d < N; d++) rst_n[d] = 1'b0;
        #1;
        for (int d = 0; d < N; d++) begin
            check("T4_async_valid", d, out_valid[d], 1'b0);
            check("T4_async_ready", d, in_ready[d], 1'b1);
            check("T4_async_data", d, out_data[d], '0);
        end
        cycle();
        for (int d = 0; d < N; d++) rst_n[d] = 1'b1;
        cycle();
        directed("T4_after", T1_IN, T1_OUT, 1'b0);

`ifdef MIXCOL_INV_EN
        directed("T5", T1_OUT, T1_IN, 1'b1);
`endif

        // T6: random traffic with stalls on both sides
        for (int d = 0; d < N; d++) base[d] = m_acc[d];
        all_done = 1'b0;
        for (int k = 0; k < 4000 && !all_done; k++) begin
            for (int d = 0; d < N; d++) begin
                in_valid[d]  = ($urandom % 2) == 0 && (m_acc[d] - base[d] < 50);
                in_data[d]   = {$urandom, $urandom, $urandom, $urandom};
                out_ready[d] = ($urandom % 4) != 0;
`ifdef MIXCOL_INV_EN
                inv[d]       = ($urandom % 2) == 1;
`endif
            end
            cycle();
            all_done = 1'b1;
            for (int d = 0; d < N; d++) if (m_acc[d] - base[d] < 50) all_done = 1'b0;
        end
        check("T6_stimulus_budget", 0, all_done, 1'b1);
        for (int d = 0; d < N; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b1;
        end
        repeat (8) cycle();
        for (int d = 0; d < N; d++) check("T6_result_count", d, dut_done[d], m_acc[d]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
